// File: rtl/mopshub_bus_scheduler.sv
// Per-bus commissioning sequencer for the MOPSHUB CAN buses: power, settle, optional trim, test, record.
// Trimming phase is built only when MOPSHUB_SCHED_TRIM_EN is defined.
module mopshub_bus_scheduler #(
  parameter int unsigned N_BUSES     = 32,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk_40_m,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] bus_mask,
  input  logic        trim_done,
  input  logic        test_done,
  input  logic        test_err,
  output logic        busy,
  output logic [4:0]  bus_sel,
  output logic        power_en,
  output logic        trim_start,
  output logic        test_start,
  output logic [31:0] bus_ok,
  output logic [31:0] bus_fail,
  output logic        done
);

  localparam int unsigned TO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned ST_W       = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TMR_W      = (TO_W > ST_W) ? TO_W : ST_W;
  localparam logic [31:0] VALID_MASK = 32'((64'd1 << N_BUSES) - 64'd1);

  typedef enum logic [3:0] {
    IDLE, SCAN, POWER, TRIM_REQ, TRIM_WAIT, TEST_REQ, TEST_WAIT, NEXT, FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pending_q, pending_d, ok_d, fail_d;
  logic [4:0]         sel_d, low_idx;
  logic [TMR_W-1:0]   tmr_q;
  logic               settled, expired, powered;
  logic               busy_d, power_d, trim_start_d, test_start_d, done_d;

`ifndef MOPSHUB_SCHED_TRIM_EN
  logic unused_trim_done;
  assign unused_trim_done = trim_done;
`endif

  // One timer serves both settle and timeout: it restarts on every state change.
  assign settled = (tmr_q == TMR_W'(SETTLE_CYC - 1));
  assign expired = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
  assign powered = (state_q == POWER) || (state_q == TRIM_REQ) || (state_q == TRIM_WAIT) ||
                   (state_q == TEST_REQ) || (state_q == TEST_WAIT);

  // Lowest set bit of the pending mask.
  always_comb begin
    low_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pending_q[i]) low_idx = 5'(i);
    end
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      tmr_q      <= '0;
      busy       <= 1'b0;
      bus_sel    <= '0;
      power_en   <= 1'b0;
      trim_start <= 1'b0;
      test_start <= 1'b0;
      bus_ok     <= '0;
      bus_fail   <= '0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      tmr_q      <= ((state_d != state_q) || (state_q == IDLE)) ? '0 : tmr_q + TMR_W'(1);
      busy       <= busy_d;
      bus_sel    <= sel_d;
      power_en   <= power_d;
      trim_start <= trim_start_d;
      test_start <= test_start_d;
      bus_ok     <= ok_d;
      bus_fail   <= fail_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = SCAN;
      SCAN:      state_d = (pending_q == '0) ? FINISH : POWER;
`ifdef MOPSHUB_SCHED_TRIM_EN
      POWER:     if (settled) state_d = TRIM_REQ;
      TRIM_REQ:  state_d = TRIM_WAIT;
      TRIM_WAIT: begin
        if (trim_done)    state_d = TEST_REQ;
        else if (expired) state_d = NEXT;
      end
`else
      POWER:     if (settled) state_d = TEST_REQ;
`endif
      TEST_REQ:  state_d = TEST_WAIT;
      TEST_WAIT: if (test_done || expired) state_d = NEXT;
      NEXT:      state_d = SCAN;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // FINISH is excluded so that done stays a single-cycle pulse.
    if (abort && (state_q != IDLE) && (state_q != FINISH)) state_d = FINISH;
  end

  always_comb begin
    pending_d    = pending_q;
    sel_d        = bus_sel;
    ok_d         = bus_ok;
    fail_d       = bus_fail;
    busy_d       = (state_d != IDLE);
    power_d      = (state_d == POWER) || (state_d == TRIM_REQ) || (state_d == TRIM_WAIT) ||
                   (state_d == TEST_REQ) || (state_d == TEST_WAIT);
    test_start_d = (state_d == TEST_REQ);
    done_d       = (state_d == FINISH);
`ifdef MOPSHUB_SCHED_TRIM_EN
    trim_start_d = (state_d == TRIM_REQ);
`else
    trim_start_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          pending_d = bus_mask & VALID_MASK;
          ok_d      = '0;
          fail_d    = '0;
        end
      end
      SCAN:      if (pending_q != '0) sel_d = low_idx;
`ifdef MOPSHUB_SCHED_TRIM_EN
      TRIM_WAIT: if (!trim_done && expired) fail_d[bus_sel] = 1'b1;
`endif
      TEST_WAIT: begin
        if (test_done) begin
          if (test_err) fail_d[bus_sel] = 1'b1;
          else          ok_d[bus_sel]   = 1'b1;
        end else if (expired) begin
          fail_d[bus_sel] = 1'b1;
        end
      end
      NEXT:      pending_d[bus_sel] = 1'b0;
      FINISH:    pending_d = '0;
      default:   ;
    endcase
    // An aborted powered bus is a failure even if its done arrived this cycle.
    if (abort && powered) begin
      fail_d[bus_sel] = 1'b1;
      ok_d[bus_sel]   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mopshub_bus_scheduler.sv
// Self-checking bench for mopshub_bus_scheduler: randomized per-bus response plans scored against a
// per-bus cycle-budget model. Also covers the MOPSHUB_SCHED_TRIM_EN build when that macro is defined.
module tb_mopshub_bus_scheduler;

  localparam int SETTLE = 4;
  localparam int TO     = 20;
  localparam int LIMIT  = 3000;

  logic        clk_40_m = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, trim_done = 1'b0, test_done = 1'b0, test_err = 1'b0;
  logic [31:0] bus_mask = '0;
  logic        busy, power_en, trim_start, test_start, done;
  logic [4:0]  bus_sel;
  logic [31:0] bus_ok, bus_fail;

  int checks = 0;
  int errors = 0;

  // Response plan per bus: delay in wait cycles (0 = never answers), error flag, trim delay.
  int dly[32];
  bit err_b[32];
  int tdly[32];

  int obs_done, obs_power, obs_tst, obs_trst;
  bit obs_both, obs_pwr_done;
  int obs_sel[$];
  int obs_wait[$];

  int e_done, e_power, e_tst, e_trst;
  logic [31:0] e_ok, e_fail;
  int e_sel[$];
  int e_wait[$];

  mopshub_bus_scheduler #(.N_BUSES(32), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TO)) dut (
    .clk_40_m(clk_40_m), .rst(rst), .start(start), .abort(abort), .bus_mask(bus_mask),
    .trim_done(trim_done), .test_done(test_done), .test_err(test_err), .busy(busy),
    .bus_sel(bus_sel), .power_en(power_en), .trim_start(trim_start), .test_start(test_start),
    .bus_ok(bus_ok), .bus_fail(bus_fail), .done(done)
  );

  always #5 clk_40_m = ~clk_40_m;

  task automatic tick();
    @(posedge clk_40_m);
    #1;
  endtask

  task automatic set_plan(input int d, input bit e);
    for (int i = 0; i < 32; i++) begin
      dly[i] = d; err_b[i] = e; tdly[i] = 1;
    end
  endtask

  // Per-bus cycle budget: SCAN + SETTLE power + [trim req + wait] + test req + wait + NEXT.
  task automatic model_scan(input logic [31:0] mask, input int abort_bus);
    int cyc, w;
    bit stop, ans;
    e_ok = '0; e_fail = '0; e_power = 0; e_tst = 0; e_trst = 0; e_done = -1;
    e_sel.delete(); e_wait.delete();
    cyc = 1; stop = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!mask[i] || stop) continue;
      cyc += 1 + SETTLE; e_power += SETTLE;
`ifdef MOPSHUB_SCHED_TRIM_EN
      e_trst++; cyc += 1; e_power += 1;
      if (!(tdly[i] >= 1 && tdly[i] <= TO)) begin
        e_fail[i] = 1'b1; e_power += TO; cyc += TO + 1;
        continue;
      end
      e_power += tdly[i]; cyc += tdly[i];
`endif
      e_tst++; e_sel.push_back(i); cyc += 1; e_power += 1;
      if (i == abort_bus) begin
        e_fail[i] = 1'b1; e_wait.push_back(1); e_power += 1; e_done = cyc + 1; stop = 1'b1;
        continue;
      end
      ans = (dly[i] >= 1 && dly[i] <= TO);
      w = ans ? dly[i] : TO;
      e_wait.push_back(w); e_power += w; cyc += w + 1;
      if (ans && !err_b[i]) e_ok[i] = 1'b1;
      else                  e_fail[i] = 1'b1;
    end
    if (!stop) e_done = cyc + 1;
  endtask

  // Starts a scan in an idle cycle and acts as the trim/test datapath until done (or LIMIT).
  task automatic run_scan(input logic [31:0] mask, input int abort_bus, input bit stray);
    int req_cyc, trq;
    bit stray_done;
    obs_done = -1; obs_power = 0; obs_tst = 0; obs_trst = 0; obs_both = 1'b0; obs_pwr_done = 1'b0;
    obs_sel.delete(); obs_wait.delete();
    req_cyc = -1; trq = -1; stray_done = 1'b0;
    tick();
    bus_mask = mask; start = 1'b1;
    for (int t = 1; t <= LIMIT && obs_done < 0; t++) begin
      tick();
      start = 1'b0; abort = 1'b0; test_done = 1'b0; test_err = 1'b0; trim_done = 1'b0;
      if ((bus_ok & bus_fail) != '0) obs_both = 1'b1;
      if (power_en) obs_power++;
      if (trim_start) begin obs_trst++; trq = t; end
      if (test_start) begin obs_tst++; obs_sel.push_back(int'(bus_sel)); req_cyc = t; end
      if (!power_en && req_cyc >= 0) obs_wait.push_back(t - req_cyc - 1);
      if (!power_en) begin req_cyc = -1; trq = -1; end
      if (done) begin
        obs_done = t; obs_pwr_done = power_en;
      end else begin
        if (trq >= 0 && req_cyc < 0 && tdly[bus_sel] != 0 && t == trq + tdly[bus_sel]) trim_done = 1'b1;
        if (req_cyc >= 0 && dly[bus_sel] != 0 && t == req_cyc + dly[bus_sel]) begin
          test_done = 1'b1; test_err = err_b[bus_sel];
        end
        if (req_cyc >= 0 && int'(bus_sel) == abort_bus && t == req_cyc + 1) abort = 1'b1;
        if (stray && !stray_done && power_en && req_cyc < 0 && trq < 0) begin
          start = 1'b1; test_done = 1'b1; stray_done = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, power_en, trim_start, test_start, done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, power_en, trim_start, test_start, done});
    end
    checks++;
    if ({bus_sel, bus_ok, bus_fail} !== 69'b0) begin
      errors++; $display("FAIL reset_data got sel %0d ok %h fail %h want 0", bus_sel, bus_ok, bus_fail);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_empty();
    set_plan(1, 1'b0);
    run_scan(32'h0, -1, 1'b0);
    checks++;
    if (obs_done !== 2) begin errors++; $display("FAIL empty_done got %0d want 2", obs_done); end
    checks++;
    if (obs_power !== 0) begin errors++; $display("FAIL empty_power got %0d want 0", obs_power); end
    checks++;
    if ({bus_ok, bus_fail} !== 64'b0) begin
      errors++; $display("FAIL empty_flags got ok %h fail %h want 0", bus_ok, bus_fail);
    end
  endtask

  task automatic test_three_buses();
    bit bad;
    set_plan(1, 1'b0);
    model_scan(32'h25, -1);
    run_scan(32'h25, -1, 1'b0);
    checks++;
    if (obs_done !== e_done) begin errors++; $display("FAIL three_done got %0d want %0d", obs_done, e_done); end
    checks++;
    bad = (obs_sel.size() != 3);
    if (!bad) bad = (obs_sel[0] != 0) || (obs_sel[1] != 2) || (obs_sel[2] != 5);
    if (bad) begin errors++; $display("FAIL three_order got %0d entries want 0,2,5", obs_sel.size()); end
    checks++;
    if (bus_ok !== 32'h25) begin errors++; $display("FAIL three_ok got %h want 00000025", bus_ok); end
    checks++;
    if (bus_fail !== 32'h0) begin errors++; $display("FAIL three_fail got %h want 0", bus_fail); end
    checks++;
    if (obs_power !== e_power) begin errors++; $display("FAIL three_power got %0d want %0d", obs_power, e_power); end
  endtask

  task automatic test_err_timeout();
    set_plan(1, 1'b0);
    err_b[0] = 1'b1; dly[1] = 0;
    model_scan(32'h3, -1);
    run_scan(32'h3, -1, 1'b0);
    checks++;
    if (bus_fail !== 32'h3) begin errors++; $display("FAIL errto_fail got %h want 00000003", bus_fail); end
    checks++;
    if (bus_ok !== 32'h0) begin errors++; $display("FAIL errto_ok got %h want 0", bus_ok); end
    checks++;
    if (obs_wait.size() != 2 || obs_wait[1] != TO) begin
      errors++; $display("FAIL errto_wait entries %0d last %0d want %0d", obs_wait.size(),
                         (obs_wait.size() > 0) ? obs_wait[obs_wait.size()-1] : -1, TO);
    end
    checks++;
    if (obs_done !== e_done) begin errors++; $display("FAIL errto_done got %0d want %0d", obs_done, e_done); end
  endtask

  task automatic test_abort();
    set_plan(1, 1'b0);
    model_scan(32'h7, 1);
    run_scan(32'h7, 1, 1'b0);
    checks++;
    if (obs_done !== e_done) begin errors++; $display("FAIL abort_done got %0d want %0d", obs_done, e_done); end
    checks++;
    if (bus_ok !== 32'h1) begin errors++; $display("FAIL abort_ok got %h want 00000001", bus_ok); end
    checks++;
    if (bus_fail !== 32'h2) begin errors++; $display("FAIL abort_fail got %h want 00000002", bus_fail); end
    checks++;
    if (obs_pwr_done !== 1'b0) begin errors++; $display("FAIL abort_power got %b want 0", obs_pwr_done); end
  endtask

  task automatic test_tie_and_stray();
    set_plan(TO, 1'b0);
    model_scan(32'h1, -1);
    run_scan(32'h1, -1, 1'b1);
    checks++;
    if (bus_ok !== 32'h1 || bus_fail !== 32'h0) begin
      errors++; $display("FAIL tie_flags got ok %h fail %h want ok 00000001 fail 0", bus_ok, bus_fail);
    end
    checks++;
    if (obs_done !== e_done) begin errors++; $display("FAIL stray_done got %0d want %0d", obs_done, e_done); end
    checks++;
    if (obs_tst !== 1) begin errors++; $display("FAIL stray_tstart got %0d want 1", obs_tst); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stray_idle busy got %b want 0", busy); end
  endtask

`ifdef MOPSHUB_SCHED_TRIM_EN
  task automatic test_trim_withheld();
    set_plan(1, 1'b0);
    tdly[0] = 0;
    model_scan(32'h3, -1);
    run_scan(32'h3, -1, 1'b0);
    checks++;
    if (bus_fail !== 32'h1 || bus_ok !== 32'h2) begin
      errors++; $display("FAIL trim_flags got ok %h fail %h want ok 00000002 fail 00000001", bus_ok, bus_fail);
    end
    checks++;
    if (obs_tst !== 1 || obs_sel.size() != 1 || obs_sel[0] != 1) begin
      errors++; $display("FAIL trim_tstart got %0d requests want 1 for bus 1", obs_tst);
    end
    checks++;
    if (obs_trst !== 2) begin errors++; $display("FAIL trim_count got %0d want 2", obs_trst); end
    checks++;
    if (obs_done !== e_done) begin errors++; $display("FAIL trim_done got %0d want %0d", obs_done, e_done); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] mask;
    bit bad;
    for (int it = 0; it < 4; it++) begin
      mask = $urandom;
      for (int i = 0; i < 32; i++) begin
        dly[i] = $urandom_range(0, 22); err_b[i] = 1'($urandom_range(0, 1));
        tdly[i] = $urandom_range(0, 3);
      end
      model_scan(mask, -1);
      run_scan(mask, -1, 1'b0);
      checks++;
      if (obs_done !== e_done) begin errors++; $display("FAIL rnd%0d_done got %0d want %0d", it, obs_done, e_done); end
      checks++;
      if (bus_ok !== e_ok) begin errors++; $display("FAIL rnd%0d_ok got %h want %h", it, bus_ok, e_ok); end
      checks++;
      if (bus_fail !== e_fail) begin errors++; $display("FAIL rnd%0d_fail got %h want %h", it, bus_fail, e_fail); end
      checks++;
      if (obs_power !== e_power) begin errors++; $display("FAIL rnd%0d_power got %0d want %0d", it, obs_power, e_power); end
      checks++;
      if (obs_trst !== e_trst) begin errors++; $display("FAIL rnd%0d_trim got %0d want %0d", it, obs_trst, e_trst); end
      checks++;
      bad = (obs_sel.size() != e_sel.size()) || (obs_wait.size() != e_wait.size());
      for (int k = 0; k < obs_sel.size() && !bad; k++) if (obs_sel[k] != e_sel[k]) bad = 1'b1;
      for (int k = 0; k < obs_wait.size() && !bad; k++) if (obs_wait[k] != e_wait[k]) bad = 1'b1;
      if (bad) begin
        errors++; $display("FAIL rnd%0d_seq got %0d/%0d entries want %0d/%0d", it,
                           obs_sel.size(), obs_wait.size(), e_sel.size(), e_wait.size());
      end
      checks++;
      if (obs_both !== 1'b0) begin errors++; $display("FAIL rnd%0d_exclusive got %b want 0", it, obs_both); end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_idle got busy %b done %b want 0 0", it, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_plan(0, 1'b0);
    tick();
    bus_mask = 32'h3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    checks++;
    if (bus_fail !== 32'h1 || power_en !== 1'b1 || bus_sel !== 5'd1) begin
      errors++; $display("FAIL midrst_pre got fail %h pwr %b sel %0d want 00000001 1 1", bus_fail, power_en, bus_sel);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, power_en, trim_start, test_start, done, bus_sel, bus_ok, bus_fail} !== 74'b0) begin
      errors++; $display("FAIL midrst_post got busy %b pwr %b sel %0d ok %h fail %h want all 0",
                         busy, power_en, bus_sel, bus_ok, bus_fail);
    end
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_empty();
    test_three_buses();
    test_err_timeout();
    test_abort();
    test_tie_and_stray();
`ifdef MOPSHUB_SCHED_TRIM_EN
    test_trim_withheld();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mopshub_bus_scheduler.md
# mopshub_bus_scheduler

Sequences per-bus commissioning of the MOPSHUB CAN buses: walks an enabled-bus mask in ascending order and, for each bus, powers it, waits for settling, optionally runs oscillator trimming, runs one test transaction, and records pass/fail. It sits beside `mopshub_top`. It drives bus selection and power enable, and hands start/done handshakes to the trimming and test datapaths. It replaces ad-hoc sequencing of those phases with one auditable FSM.

## Interface
Parameters:
- `N_BUSES`, 32, number of buses scanned (1..32); mask bits at and above `N_BUSES` are ignored.
- `SETTLE_CYC`, 16, number of cycles `power_en` is held before the first request (≥1).
- `TIMEOUT_CYC`, 4096, maximum cycles spent in a wait state before the bus is declared failed (≥1).

Ports:
- `clk_40_m`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a scan; ignored while `busy`.
- `abort`  in  1  level; terminates the scan.
- `bus_mask`  in  32  buses to process; sampled on an accepted `start`.
- `trim_done`  in  1  trimming-complete pulse.
- `test_done`  in  1  test-complete pulse.
- `test_err`  in  1  error qualifier; sampled only with `test_done`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `bus_sel`  out  5  index of the bus under service.
- `power_en`  out  1  power enable for `bus_sel`.
- `trim_start`  out  1  one-cycle request to the trimming datapath.
- `test_start`  out  1  one-cycle request to the test datapath.
- `bus_ok`  out  32  per-bus pass flags.
- `bus_fail`  out  32  per-bus fail flags.
- `done`  out  1  one-cycle end-of-scan pulse.

## Operation
- FSM states: `IDLE`, `SCAN`, `POWER`, `TRIM_REQ`, `TRIM_WAIT`, `TEST_REQ`, `TEST_WAIT`, `NEXT`, `FINISH`.
- All outputs are registered, Moore-decoded from state.
- **IDLE**
  - On `start`: latch `bus_mask & ((1<<N_BUSES)-1)` into `pending`, clear `bus_ok` and `bus_fail`, go to `SCAN`.
- **SCAN**
  - A priority encoder selects the lowest set bit of `pending` and loads it into `bus_sel`; go to `POWER`.
  - If `pending` is 0, go to `FINISH`.
- **POWER**
  - `power_en` is high; the settle counter runs `SETTLE_CYC` cycles.
  - Then go to `TRIM_REQ` (if trimming is compiled in) or to `TEST_REQ`.
- **TRIM_REQ**
  - `trim_start` is high for 1 cycle; go to `TRIM_WAIT`.
- **TRIM_WAIT**
  - On `trim_done`, go to `TEST_REQ`.
  - On timeout, set `bus_fail[bus_sel]` and go to `NEXT`; the test is skipped.
- **TEST_REQ**
  - `test_start` is high for 1 cycle; go to `TEST_WAIT`.
- **TEST_WAIT**
  - On `test_done`, set `bus_ok[bus_sel]` if `!test_err`, else set `bus_fail[bus_sel]`; go to `NEXT`.
  - On timeout, set `bus_fail[bus_sel]`; go to `NEXT`.
- **NEXT**
  - `power_en` is low; clear `pending[bus_sel]`; go to `SCAN`.
- **FINISH**
  - `done` is high for 1 cycle; go to `IDLE`.
- `power_en` is high in `POWER`, `TRIM_REQ`, `TRIM_WAIT`, `TEST_REQ` and `TEST_WAIT`, and low in every other state.
- The timeout counter is `$clog2(TIMEOUT_CYC+1)` bits wide. It is cleared on entry to each wait state and expires on its `TIMEOUT_CYC`-th cycle in that state.
- If a done input and timeout expiry occur in the same cycle, the done input wins.
- `trim_done`, `test_done` and `test_err` are ignored outside their wait state.
- **Abort**
  - `abort` in any non-`IDLE` state forces `FINISH` on the next cycle.
  - If a bus was powered, it is marked `bus_fail` and `power_en` drops.
  - Unprocessed buses keep both flags at 0.
  - `abort` in `IDLE` has no effect.
- An accepted `start` never coincides with `busy`: `start` while `busy` is dropped.
- `bus_ok[i]` and `bus_fail[i]` are never both set.

## Timing
- **Reset** (`rst`=0 at a clock edge): state `IDLE`; `busy`, `power_en`, `trim_start`, `test_start`, `done`=0; `bus_sel`=0; `bus_ok`, `bus_fail`, `pending`=0.
- Reset mid-scan takes effect on the same edge and discards results.
- **Latency per bus**, with a done input arriving in the first wait cycle:
  - trimming compiled out: `SETTLE_CYC`+4 cycles (`SCAN`, `POWER`×`SETTLE_CYC`, `TEST_REQ`, `TEST_WAIT`, `NEXT`);
  - trimming compiled in: `SETTLE_CYC`+6 cycles.
- **Scan overhead:** `start`→`SCAN` takes 1 cycle; the final `SCAN`→`FINISH` takes 1 cycle.
- **Example** (trimming out, `SETTLE_CYC`=4, one bus, `test_done` at the first `TEST_WAIT` cycle):
  - `start` at cycle 0;
  - `power_en` high in cycles 2–7;
  - `test_start` high in cycle 6;
  - `done` high in cycle 10.

## Configuration
- Macro: `MOPSHUB_SCHED_TRIM_EN`.
- Defined: `TRIM_REQ` and `TRIM_WAIT` are built in, and every bus is trimmed before its test.
- Undefined: those states are not built, `POWER` goes directly to `TEST_REQ`, `trim_start` is tied to 0 and `trim_done` is unused.

## Test plan
All scenarios use `SETTLE_CYC`=4 and `TIMEOUT_CYC`=20.
- **Empty mask:** `bus_mask`=0, `start` → `done` 2 cycles later, `power_en` never high, `bus_ok`=`bus_fail`=0.
- **Three buses:** `bus_mask`=`0x0000_0025`, every `test_done` with `test_err`=0 → `bus_sel` visits 0, 2, 5 in order; `bus_ok`=`0x25`, `bus_fail`=0.
- **Error and timeout:** `bus_mask`=`0x3`; bus 0 returns `test_done` with `test_err`=1; bus 1 never answers → `bus_fail`=`0x3`. Bus 1 spends exactly 20 cycles in `TEST_WAIT`.
- **Abort:** `abort` during bus 1's `TEST_WAIT`, with `bus_mask`=`0x7` → `done` on the next cycle; `bus_ok`=`0x1`, `bus_fail`=`0x2`; bit 2 clear in both; `power_en` 0.
- **Tie and stray handshakes:** `test_done` in the same cycle as timeout expiry → pass recorded. `start` and `test_done` pulsed during `POWER` → both ignored.
- **Trimming compiled in:** `MOPSHUB_SCHED_TRIM_EN` defined, `trim_done` withheld → `bus_fail` set and `test_start` never asserted for that bus. Reset asserted mid-scan → all outputs return to reset values on the next edge.
